note_tone_gen: RTL

- Downstream consumer of the 4-bit note stream produced by the sound-series sequencer.
- Converts each note code into an audible square wave at the note's pitch (C4..C5, 10 MHz system clock).
- Applies a linear attack/release amplitude envelope so note starts, stops and rests are click-free.
- Emits an 8-bit unsigned sample, centred at 128, to the PWM/DAC output stage.

---
 rtl/synth_pkg.sv | 53 +++++
 rtl/tone_divider.sv | 47 ++++
 rtl/note_tone_gen.sv | 130 +++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the sound-series sequencer and its tone generator.
package synth_pkg;

   // Note codes carried on the 4-bit note stream.
   typedef enum logic [3:0] {
      C   = 4'h0,
      Cs  = 4'h1,
      D   = 4'h2,
      Ds  = 4'h3,
      E   = 4'h4,
      F   = 4'h5,
      Fs  = 4'h6,
      G   = 4'h7,
      Gs  = 4'h8,
      A   = 4'h9,
      As  = 4'hA,
      B   = 4'hB,
      Ch  = 4'hC,
      OFF = 4'hF
   } tone_t;

   // Highest code that produces a pitch; everything above is a rest.
   localparam logic [3:0] NOTE_MAX = 4'hC;

   // Envelope FSM states.
   typedef enum logic [1:0] {
      IDLE,
      ATTACK,
      SUSTAIN,
      RELEASE
   } env_state_t;

   // Half-period in 10 MHz clock cycles for each playable note (C4..C5).
   function automatic logic [14:0] half_period(input logic [3:0] code);
      case (code)
         4'h0:    half_period = 15'd19111;
         4'h1:    half_period = 15'd18039;
         4'h2:    half_period = 15'd17026;
         4'h3:    half_period = 15'd16071;
         4'h4:    half_period = 15'd15169;
         4'h5:    half_period = 15'd14317;
         4'h6:    half_period = 15'd13514;
         4'h7:    half_period = 15'd12755;
         4'h8:    half_period = 15'd12039;
         4'h9:    half_period = 15'd11364;
         4'hA:    half_period = 15'd10726;
         4'hB:    half_period = 15'd10124;
         4'hC:    half_period = 15'd9556;
         default: half_period = '0;
      endcase
   endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave phase generator with glitch-free pitch changes: a new
// half-period is parked in pend_hp and only takes effect at a phase boundary.
module tone_divider (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic        run,
   input  logic        load_pend,
   input  logic [14:0] lut_hp,
   output logic        phase
);

   logic [14:0] cnt;
   logic [14:0] pend_hp;
   logic [14:0] active_hp;

   // Phase counter; counts elapsed cycles up to active_hp-1 rather than
   // down to 0, which gives the same phase lengths and keeps active_hp
   // as the live compare value.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt       <= '0;
         pend_hp   <= '0;
         active_hp <= '0;
         phase     <= 1'b1;
      end else if (start) begin
         cnt       <= '0;
         pend_hp   <= lut_hp;
         active_hp <= lut_hp;
         phase     <= 1'b1;
      end else begin
         if (load_pend) begin
            pend_hp <= lut_hp;
         end
         if (run) begin
            if (cnt == active_hp - 15'd1) begin
               cnt       <= '0;
               phase     <= ~phase;
               active_hp <= pend_hp;
            end else begin
               cnt <= cnt + 15'd1;
            end
         end
      end
   end

endmodule

// File: rtl/note_tone_gen.sv
// Note-code to square-wave voice with a linear attack/release envelope,
// producing an unsigned 8-bit sample centred on 128.
module note_tone_gen
   import synth_pkg::*;
#(
   parameter int unsigned ENV_DIV = 1024,
   parameter int unsigned AMP_MAX = 127
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [3:0] note_in,
   input  logic       en,
   output logic [7:0] wave_out,
   output logic       note_active
);

   localparam logic [15:0] PRESC_LAST = 16'(ENV_DIV - 1);
   localparam logic [6:0]  AMP_TOP    = 7'(AMP_MAX);

   logic [3:0]  note_q;
   env_state_t  state;
   env_state_t  state_next;
   logic [6:0]  amp;
   logic [6:0]  amp_next;
   logic [15:0] presc;
   logic        tick;
   logic        valid;
   logic        start;
   logic        run;
   logic        phase;
   logic [14:0] lut_hp;

   assign valid       = en && (note_q <= NOTE_MAX);
   assign start       = (state == IDLE) && valid;
   assign run         = (state != IDLE);
   assign tick        = (presc == PRESC_LAST);
   assign lut_hp      = half_period(note_q);
   assign note_active = (state != IDLE);

   // Register the incoming note so the FSM never sees note_in directly.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         note_q <= OFF;
      end else begin
         note_q <= note_in;
      end
   end

   // Envelope step prescaler; parked at 0 while the voice is idle.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         presc <= '0;
      end else if (state == IDLE || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 16'd1;
      end
   end

   // Envelope state and amplitude registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
         amp   <= '0;
      end else begin
         state <= state_next;
         amp   <= amp_next;
      end
   end

   // Envelope next-state and amplitude stepping.
   always_comb begin
      state_next = state;
      amp_next   = amp;
      case (state)
         IDLE: begin
            amp_next = '0;
            if (valid) begin
               state_next = ATTACK;
            end
         end
         ATTACK: begin
            if (!valid) begin
               state_next = RELEASE;
            end else if (amp >= AMP_TOP) begin
               state_next = SUSTAIN;
            end else if (tick) begin
               amp_next = amp + 7'd1;
               if (amp_next == AMP_TOP) begin
                  state_next = SUSTAIN;
               end
            end
         end
         SUSTAIN: begin
            if (!valid) begin
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            if (valid) begin
               state_next = ATTACK;
            end else if (amp == '0) begin
               state_next = IDLE;
            end else if (tick) begin
               amp_next = amp - 7'd1;
            end
         end
         default: begin
            state_next = IDLE;
            amp_next   = '0;
         end
      endcase
   end

   tone_divider u_tone_divider (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .run       (run),
      .load_pend (valid),
      .lut_hp    (lut_hp),
      .phase     (phase)
   );

   // Map phase and amplitude onto the unsigned sample.
   always_comb begin
      wave_out = phase ? (8'd128 + {1'b0, amp}) : (8'd128 - {1'b0, amp});
   end

endmodule
